// File: rtl/uart_frame_parser.sv
// Byte-stream frame parser: syncs on AA 55, collects LEN, payload and CHK, and
// releases the buffered payload on a valid/ready stream only after CHK matches.
module uart_frame_parser #(
  parameter int MAX_LEN = 32,
  parameter int TIMEOUT = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       rx_perr_i,
  output logic [7:0] pl_data_o,
  output logic       pl_valid_o,
  input  logic       pl_ready_i,
  output logic       pl_last_o,
  output logic       pkt_ok_o,
  output logic       pkt_err_o,
  output logic       overrun_o
);
  localparam int IDXW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_HUNT1, S_HUNT2, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    wr_idx_q, wr_idx_d;
  logic [7:0]    rd_idx_q, rd_idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    pl_data_q, pl_data_d;
  logic          pl_valid_q, pl_valid_d;
  logic          pl_last_q, pl_last_d;
  logic          pkt_ok_q, pkt_ok_d;
  logic          pkt_err_q, pkt_err_d;
  logic          overrun_q, overrun_d;
  logic          mem_we;
  logic          in_frame;
  logic [7:0]    wr_next, rd_next;
  logic [7:0]    mem_q [MAX_LEN];

  assign wr_next  = wr_idx_q + 8'd1;
  assign rd_next  = rd_idx_q + 8'd1;
  assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);

  // Payload stream: a byte moves when pl_valid_o && pl_ready_i on a rising edge;
  // while pl_valid_o is high and pl_ready_i low, pl_data_o/pl_last_o hold.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    sum_d      = sum_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    timer_d    = in_frame ? (rx_valid_i ? '0 : timer_q + TW'(1)) : '0;
    pl_data_d  = pl_data_q;
    pl_valid_d = pl_valid_q;
    pl_last_d  = pl_last_q;
    pkt_ok_d   = 1'b0;
    pkt_err_d  = 1'b0;
    overrun_d  = overrun_q;
    mem_we     = 1'b0;
    unique case (state_q)
      S_HUNT1: if (rx_valid_i && rx_data_i == 8'hAA) state_d = S_HUNT2;
      S_HUNT2: begin
        if (rx_valid_i) begin
          if (rx_perr_i)                state_d = S_HUNT1;
          else if (rx_data_i == 8'h55)  state_d = S_LEN;
          else if (rx_data_i != 8'hAA)  state_d = S_HUNT1;
        end
      end
      S_LEN: begin
        if (rx_valid_i) begin
          if (rx_perr_i || rx_data_i == 8'd0 || rx_data_i > MAX_LEN_B) begin
            pkt_err_d = 1'b1;
            state_d   = S_HUNT1;
          end else begin
            len_d    = rx_data_i;
            sum_d    = rx_data_i;
            wr_idx_d = 8'd0;
            state_d  = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_valid_i) begin
          if (rx_perr_i) begin
            pkt_err_d = 1'b1;
            state_d   = S_HUNT1;
          end else begin
            mem_we   = 1'b1;
            sum_d    = sum_q + rx_data_i;
            wr_idx_d = wr_next;
            if (wr_next == len_q) state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (rx_valid_i) begin
          if (!rx_perr_i && rx_data_i == sum_q) begin
            pkt_ok_d   = 1'b1;
            state_d    = S_DRAIN;
            rd_idx_d   = 8'd0;
            pl_valid_d = 1'b1;
            pl_data_d  = mem_q[0];
            pl_last_d  = (len_q == 8'd1);
          end else begin
            pkt_err_d = 1'b1;
            state_d   = S_HUNT1;
          end
        end
      end
      S_DRAIN: begin
        if (rx_valid_i) overrun_d = 1'b1;
        if (pl_ready_i) begin
          if (pl_last_q) begin
            state_d    = S_HUNT1;
            pl_valid_d = 1'b0;
            pl_last_d  = 1'b0;
          end else begin
            rd_idx_d  = rd_next;
            pl_data_d = mem_q[rd_next[IDXW-1:0]];
            pl_last_d = (rd_next == len_q - 8'd1);
          end
        end
      end
      default: state_d = S_HUNT1;
    endcase
    // An arriving byte always beats an expiring gap timer.
    if (in_frame && !rx_valid_i && timer_q == TIMEOUT_CNT) begin
      pkt_err_d = 1'b1;
      state_d   = S_HUNT1;
    end
    if (pkt_ok_d) overrun_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_HUNT1;
      len_q      <= 8'd0;
      sum_q      <= 8'd0;
      wr_idx_q   <= 8'd0;
      rd_idx_q   <= 8'd0;
      timer_q    <= '0;
      pl_data_q  <= 8'd0;
      pl_valid_q <= 1'b0;
      pl_last_q  <= 1'b0;
      pkt_ok_q   <= 1'b0;
      pkt_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      sum_q      <= sum_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      timer_q    <= timer_d;
      pl_data_q  <= pl_data_d;
      pl_valid_q <= pl_valid_d;
      pl_last_q  <= pl_last_d;
      pkt_ok_q   <= pkt_ok_d;
      pkt_err_q  <= pkt_err_d;
      overrun_q  <= overrun_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[wr_idx_q[IDXW-1:0]] <= rx_data_i;
  end

  assign pl_data_o  = pl_data_q;
  assign pl_valid_o = pl_valid_q;
  assign pl_last_o  = pl_last_q;
  assign pkt_ok_o   = pkt_ok_q;
  assign pkt_err_o  = pkt_err_q;
  assign overrun_o  = overrun_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed scenarios plus random frames scored
// against a byte-stream reference parser written with plain index arithmetic.
module tb_uart_frame_parser;
  localparam int MAX_LEN = 32;
  localparam int TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_perr = 1'b0;
  logic       pl_ready = 1'b1;
  logic [7:0] pl_data;
  logic       pl_valid, pl_last, pkt_ok, pkt_err, overrun;

  int checks = 0, failures = 0;
  int ok_cnt = 0, err_cnt = 0, both_cnt = 0, hold_viol = 0;
  int exp_ok = 0, exp_err = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  logic [7:0] stream_b[$];
  logic       stream_p[$];
  logic       hold_q = 1'b0;
  logic [8:0] hold_val = '0;

  uart_frame_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_perr_i(rx_perr), .pl_data_o(pl_data), .pl_valid_o(pl_valid),
    .pl_ready_i(pl_ready), .pl_last_o(pl_last), .pkt_ok_o(pkt_ok),
    .pkt_err_o(pkt_err), .overrun_o(overrun)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // observer: pulse counts, handshake capture, hold-stability tracking
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_q = 1'b0;
    end else begin
      if (pkt_ok && pkt_err) both_cnt++;
      if (pkt_ok) ok_cnt++;
      if (pkt_err) err_cnt++;
      if (hold_q && (!pl_valid || {pl_last, pl_data} !== hold_val)) hold_viol++;
      hold_q   = pl_valid && !pl_ready;
      hold_val = {pl_last, pl_data};
      if (pl_valid && pl_ready) obs_q.push_back({pl_last, pl_data});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic p);
    rx_data  = b;
    rx_perr  = p;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_perr  = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input logic p);
    stream_b.push_back(b);
    stream_p.push_back(p);
  endtask

  task automatic new_stream();
    stream_b.delete();
    stream_p.delete();
  endtask

  task automatic clear_sb();
    new_stream();
    exp_q.delete();
    obs_q.delete();
    exp_ok  = ok_cnt;
    exp_err = err_cnt;
  endtask

  // No gap after the final byte so callers can sample its result directly.
  task automatic send_stream(input int gap_max);
    for (int i = 0; i < stream_b.size(); i++) begin
      send_byte(stream_b[i], stream_p[i]);
      if (i != stream_b.size() - 1) repeat ($urandom_range(0, gap_max)) tick();
    end
  endtask

  task automatic wait_idle(output bit to, input bit rand_ready);
    int c = 0;
    while (pl_valid && c < 1000) begin
      if (rand_ready) pl_ready = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    to = pl_valid;
    pl_ready = 1'b1;
    tick();
    tick();
  endtask

  // Reference parser over the whole byte stream: find sync, then judge the
  // frame by length bounds, parity flags and the modulo-256 checksum.
  function automatic void model_stream();
    int i, j, k, n, len, sum, abort;
    logic lst;
    i = 0;
    n = stream_b.size();
    while (i < n) begin
      if (stream_b[i] != 8'hAA) begin i++; continue; end
      j = i + 1;
      while (j < n && stream_b[j] == 8'hAA && !stream_p[j]) j++;
      if (j + 1 >= n) break;
      if (stream_p[j] || stream_b[j] != 8'h55) begin i = j + 1; continue; end
      len = int'(stream_b[j+1]);
      if (stream_p[j+1] || len == 0 || len > MAX_LEN) begin exp_err++; i = j + 2; continue; end
      k = j + 2;
      abort = -1;
      for (int m = k; m <= k + len && m < n; m++) if (stream_p[m]) begin abort = m; break; end
      if (abort >= 0) begin exp_err++; i = abort + 1; continue; end
      if (k + len >= n) break;
      sum = len;
      for (int m = 0; m < len; m++) sum += int'(stream_b[k+m]);
      if (stream_b[k+len] == 8'(sum % 256)) begin
        exp_ok++;
        for (int m = 0; m < len; m++) begin
          lst = (m == len - 1);
          exp_q.push_back({lst, stream_b[k+m]});
        end
      end else begin
        exp_err++;
      end
      i = k + len + 1;
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++; if (pl_data !== 8'h00) begin failures++; $display("FAIL reset_pl_data: got %0h expected 0", pl_data); end
    checks++; if (pl_valid !== 1'b0) begin failures++; $display("FAIL reset_pl_valid: got %0b expected 0", pl_valid); end
    checks++; if (pl_last !== 1'b0) begin failures++; $display("FAIL reset_pl_last: got %0b expected 0", pl_last); end
    checks++; if (pkt_ok !== 1'b0) begin failures++; $display("FAIL reset_pkt_ok: got %0b expected 0", pkt_ok); end
    checks++; if (pkt_err !== 1'b0) begin failures++; $display("FAIL reset_pkt_err: got %0b expected 0", pkt_err); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
  endtask

  task automatic test_good_frame();
    logic [11:0] exp_v[3];
    bit to;
    exp_v = '{12'hA10, 12'h220, 12'h330};  // {ok,err,valid,last,data}
    clear_sb();
    pl_ready = 1'b1;
    push(8'hAA, 0); push(8'h55, 0); push(8'h03, 0);
    push(8'h10, 0); push(8'h20, 0); push(8'h30, 0); push(8'h63, 0);
    model_stream();
    send_stream(0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({pkt_ok, pkt_err, pl_valid, pl_last, pl_data} !== exp_v[c]) begin
        failures++;
        $display("FAIL good_cycle%0d: got %0h expected %0h", c, {pkt_ok, pkt_err, pl_valid, pl_last, pl_data}, exp_v[c]);
      end
      tick();
    end
    checks++; if ({pkt_ok, pkt_err, pl_valid} !== 3'b000) begin failures++; $display("FAIL good_end: got %0b expected 000", {pkt_ok, pkt_err, pl_valid}); end
    wait_idle(to, 1'b0);
    checks++; if (ok_cnt !== exp_ok || err_cnt !== exp_err) begin failures++; $display("FAIL good_counts: got ok=%0d err=%0d expected ok=%0d err=%0d", ok_cnt, err_cnt, exp_ok, exp_err); end
    checks++; if (obs_q !== exp_q) begin failures++; $display("FAIL good_payload: got %0d bytes expected %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_bad_checksum();
    bit to;
    clear_sb();
    push(8'hAA, 0); push(8'h55, 0); push(8'h03, 0);
    push(8'h10, 0); push(8'h20, 0); push(8'h30, 0); push(8'h64, 0);
    model_stream();
    send_stream(0);
    checks++; if ({pkt_ok, pkt_err, pl_valid} !== 3'b010) begin failures++; $display("FAIL badchk_pulse: got %0b expected 010", {pkt_ok, pkt_err, pl_valid}); end
    repeat (3) tick();
    new_stream();
    push(8'hAA, 0); push(8'h55, 0); push(8'h02, 0); push(8'h40, 0); push(8'h41, 0); push(8'h83, 0);
    model_stream();
    send_stream(1);
    checks++; if ({pkt_ok, pl_valid, pl_data} !== {2'b11, 8'h40}) begin failures++; $display("FAIL badchk_recover: got %0h expected 340", {pkt_ok, pl_valid, pl_data}); end
    wait_idle(to, 1'b1);
    checks++; if (to) begin failures++; $display("FAIL badchk_drain: got stuck valid expected drained"); end
    checks++; if (ok_cnt !== exp_ok || err_cnt !== exp_err) begin failures++; $display("FAIL badchk_counts: got ok=%0d err=%0d expected ok=%0d err=%0d", ok_cnt, err_cnt, exp_ok, exp_err); end
    checks++; if (obs_q !== exp_q) begin failures++; $display("FAIL badchk_payload: got %0d bytes expected %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_len_parity();
    bit to;
    clear_sb();
    push(8'hAA, 0); push(8'h55, 0); push(8'h00, 0);
    model_stream();
    send_stream(0);
    checks++; if ({pkt_ok, pkt_err} !== 2'b01) begin failures++; $display("FAIL len_zero: got %0b expected 01", {pkt_ok, pkt_err}); end
    tick();
    new_stream();
    push(8'hAA, 0); push(8'h55, 0); push(8'h21, 0);
    model_stream();
    send_stream(0);
    checks++; if ({pkt_ok, pkt_err} !== 2'b01) begin failures++; $display("FAIL len_over: got %0b expected 01", {pkt_ok, pkt_err}); end
    tick();
    new_stream();
    push(8'hAA, 0); push(8'h55, 0); push(8'h03, 0); push(8'h10, 0); push(8'h20, 1);
    model_stream();
    send_stream(0);
    checks++; if ({pkt_ok, pkt_err, pl_valid} !== 3'b010) begin failures++; $display("FAIL parity_payload: got %0b expected 010", {pkt_ok, pkt_err, pl_valid}); end
    new_stream();
    push(8'h30, 0); push(8'h63, 0); push(8'hAA, 0); push(8'h55, 0); push(8'h01, 0); push(8'h7F, 0); push(8'h80, 0);
    model_stream();
    send_stream(0);
    checks++; if (pkt_ok !== 1'b1) begin failures++; $display("FAIL parity_rehunt: got %0b expected 1", pkt_ok); end
    wait_idle(to, 1'b0);
    checks++; if (ok_cnt !== exp_ok || err_cnt !== exp_err) begin failures++; $display("FAIL lenpar_counts: got ok=%0d err=%0d expected ok=%0d err=%0d", ok_cnt, err_cnt, exp_ok, exp_err); end
    checks++; if (obs_q !== exp_q) begin failures++; $display("FAIL lenpar_payload: got %0d bytes expected %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_sync_recovery();
    bit to;
    clear_sb();
    push(8'h12, 0); push(8'hAA, 0); push(8'hAA, 0); push(8'h55, 0); push(8'h01, 0); push(8'h7F, 0); push(8'h80, 0);
    model_stream();
    send_stream(0);
    checks++; if ({pkt_ok, pl_valid, pl_last, pl_data} !== {3'b111, 8'h7F}) begin failures++; $display("FAIL sync_aaaa55: got %0h expected 77f", {pkt_ok, pl_valid, pl_last, pl_data}); end
    wait_idle(to, 1'b0);
    new_stream();
    push(8'hAA, 0); push(8'h13, 0); push(8'h55, 0); push(8'h01, 0); push(8'h7F, 0); push(8'h80, 0);
    model_stream();
    send_stream(0);
    repeat (3) tick();
    checks++; if (ok_cnt !== exp_ok || err_cnt !== exp_err) begin failures++; $display("FAIL sync_counts: got ok=%0d err=%0d expected ok=%0d err=%0d", ok_cnt, err_cnt, exp_ok, exp_err); end
    checks++; if (obs_q !== exp_q) begin failures++; $display("FAIL sync_payload: got %0d bytes expected %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_backpressure_overrun();
    logic [3:0] pat;
    int hv0;
    bit to;
    pat = 4'b1001;
    hv0 = hold_viol;
    clear_sb();
    push(8'hAA, 0); push(8'h55, 0); push(8'h04, 0);
    push(8'h01, 0); push(8'h02, 0); push(8'h03, 0); push(8'h04, 0); push(8'h0E, 0);
    model_stream();
    send_stream(0);
    for (int c = 0; c < 64 && pl_valid; c++) begin
      pl_ready = pat[c % 4];
      if (c == 2) begin rx_data = 8'hAA; rx_valid = 1'b1; end
      tick();
      rx_valid = 1'b0;
    end
    pl_ready = 1'b1;
    checks++; if (pl_valid !== 1'b0) begin failures++; $display("FAIL bp_drain: got valid=%0b expected 0", pl_valid); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL bp_overrun_set: got %0b expected 1", overrun); end
    checks++; if (hold_viol !== hv0) begin failures++; $display("FAIL bp_hold: got %0d violations expected %0d", hold_viol, hv0); end
    new_stream();
    push(8'h55, 0); push(8'h01, 0); push(8'h7F, 0); push(8'h80, 0);
    model_stream();
    send_stream(0);
    repeat (2) tick();
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL bp_overrun_sticky: got %0b expected 1", overrun); end
    new_stream();
    push(8'hAA, 0); push(8'h55, 0); push(8'h02, 0); push(8'h05, 0); push(8'h06, 0); push(8'h0D, 0);
    model_stream();
    send_stream(0);
    checks++; if ({pkt_ok, overrun} !== 2'b10) begin failures++; $display("FAIL bp_overrun_clear: got %0b expected 10", {pkt_ok, overrun}); end
    wait_idle(to, 1'b0);
    checks++; if (ok_cnt !== exp_ok || err_cnt !== exp_err) begin failures++; $display("FAIL bp_counts: got ok=%0d err=%0d expected ok=%0d err=%0d", ok_cnt, err_cnt, exp_ok, exp_err); end
    checks++; if (obs_q !== exp_q) begin failures++; $display("FAIL bp_payload: got %0d bytes expected %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_timeout();
    int k;
    int e0;
    bit to;
    clear_sb();
    send_byte(8'hAA, 0); send_byte(8'h55, 0); send_byte(8'h02, 0); send_byte(8'h10, 0);
    k = 0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (pkt_err) begin k = c; break; end
    end
    checks++; if (k !== TIMEOUT + 1) begin failures++; $display("FAIL timeout_latency: got %0d cycles expected %0d", k, TIMEOUT + 1); end
    checks++; if (pl_valid !== 1'b0) begin failures++; $display("FAIL timeout_valid: got %0b expected 0", pl_valid); end
    repeat (2) tick();
    e0 = err_cnt;
    send_byte(8'hAA, 0); send_byte(8'h55, 0); send_byte(8'h02, 0); send_byte(8'h10, 0);
    repeat (TIMEOUT) tick();
    send_byte(8'h20, 0);
    send_byte(8'h32, 0);
    checks++; if ({pkt_ok, pkt_err, pl_data} !== {2'b10, 8'h10}) begin failures++; $display("FAIL timeout_coincide: got %0h expected 210", {pkt_ok, pkt_err, pl_data}); end
    wait_idle(to, 1'b0);
    checks++; if (err_cnt !== e0) begin failures++; $display("FAIL timeout_coincide_err: got %0d expected %0d", err_cnt, e0); end
  endtask

  task automatic test_reset_mid_drain();
    bit to;
    clear_sb();
    pl_ready = 1'b0;
    push(8'hAA, 0); push(8'h55, 0); push(8'h02, 0); push(8'h11, 0); push(8'h22, 0); push(8'h35, 0);
    send_stream(0);
    send_byte(8'h00, 0);
    checks++; if ({pl_valid, overrun, pl_data} !== {2'b11, 8'h11}) begin failures++; $display("FAIL rst_pre: got %0h expected 311", {pl_valid, overrun, pl_data}); end
    rst_n = 1'b0;
    #1;
    checks++; if ({pl_data, pl_valid, pl_last, pkt_ok, pkt_err, overrun} !== 13'd0) begin failures++; $display("FAIL rst_mid_drain: got %0h expected 0", {pl_data, pl_valid, pl_last, pkt_ok, pkt_err, overrun}); end
    tick();
    rst_n = 1'b1;
    pl_ready = 1'b1;
    tick();
    clear_sb();
    push(8'hAA, 0); push(8'h55, 0); push(8'h01, 0); push(8'h7F, 0); push(8'h80, 0);
    model_stream();
    send_stream(0);
    checks++; if ({pkt_ok, pl_valid, pl_last, pl_data} !== {3'b111, 8'h7F}) begin failures++; $display("FAIL rst_fresh: got %0h expected 77f", {pkt_ok, pl_valid, pl_last, pl_data}); end
    wait_idle(to, 1'b0);
    checks++; if (obs_q !== exp_q) begin failures++; $display("FAIL rst_payload: got %0d bytes expected %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_random();
    int kind, len, sum, nj, pstart;
    logic [7:0] b;
    bit to;
    for (int it = 0; it < 25; it++) begin
      clear_sb();
      kind = (it == 0) ? 0 : $urandom_range(0, 4);
      nj = $urandom_range(0, 3);
      for (int j = 0; j < nj; j++) begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'hAA || b == 8'h55);
        push(b, 0);
      end
      push(8'hAA, 0);
      push(8'h55, kind == 4);
      if (kind == 2) begin
        len = $urandom_range(0, 1) ? 0 : $urandom_range(MAX_LEN + 1, 255);
        push(8'(len), 0);
      end else begin
        len = (it == 0) ? MAX_LEN : $urandom_range(1, MAX_LEN);
        push(8'(len), 0);
        pstart = stream_b.size();
        sum = len;
        for (int j = 0; j < len; j++) begin
          do b = 8'($urandom_range(0, 255)); while (b == 8'hAA);
          push(b, 0);
          sum += int'(b);
        end
        push(8'((sum + ((kind == 1) ? 1 : 0)) % 256), 0);
        if (kind == 3) stream_p[pstart + $urandom_range(0, len)] = 1'b1;
      end
      model_stream();
      send_stream(2);
      wait_idle(to, 1'b1);
      checks++; if (to) begin failures++; $display("FAIL rand%0d_drain: got stuck valid expected drained", it); end
      checks++; if (ok_cnt !== exp_ok || err_cnt !== exp_err) begin failures++; $display("FAIL rand%0d_counts: got ok=%0d err=%0d expected ok=%0d err=%0d", it, ok_cnt, err_cnt, exp_ok, exp_err); end
      checks++; if (obs_q !== exp_q) begin failures++; $display("FAIL rand%0d_payload: got %0d bytes expected %0d", it, obs_q.size(), exp_q.size()); end
    end
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL ok_err_overlap: got %0d expected 0", both_cnt); end
    checks++; if (hold_viol !== 0) begin failures++; $display("FAIL hold_stability: got %0d expected 0", hold_viol); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_len_parity();
    test_sync_recovery();
    test_backpressure_overrun();
    test_timeout();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-level frame parser downstream of the UART receiver. It consumes received bytes and parity-error flags and hunts for the sync header 0xAA 0x55. It then takes a length byte, the payload and a checksum byte, buffers the payload, and releases it over a valid/ready stream only when the checksum verifies. It feeds the BCI command/sample logic and turns the raw serial byte stream into validated packets.

## Interface
Parameters:
- MAX_LEN, 32: maximum payload bytes (1..255); sets buffer depth.
- TIMEOUT, 50000: inter-byte gap limit in clk cycles while a frame is open.

Ports:
- clk  in  1  system clock; one clock domain, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- rx_perr  in  1  parity error for the current byte; sampled only with rx_valid.
- pl_data  out  8  payload byte.
- pl_valid  out  1  pl_data valid.
- pl_ready  in  1  consumer accepts pl_data.
- pl_last  out  1  final payload byte of the frame; qualified by pl_valid.
- pkt_ok  out  1  one-cycle pulse: frame passed the checksum.
- pkt_err  out  1  one-cycle pulse: frame aborted (bad length, checksum, parity or timeout).
- overrun  out  1  sticky: a byte arrived during DRAIN and was discarded; cleared by the next pkt_ok.

## Operation
- Frame on the wire: 0xAA, 0x55, LEN, LEN payload bytes, CHK.
- CHK = (LEN + sum of payload) mod 256, 8-bit wrap.
- States: HUNT1, HUNT2, LEN, PAYLOAD, CHK, DRAIN.
- HUNT1: byte 0xAA goes to HUNT2; any other byte is ignored. rx_perr is ignored in HUNT1.
- HUNT2: 0x55 goes to LEN. 0xAA stays in HUNT2, so AA AA 55 still syncs. Any other byte goes to HUNT1, with no pkt_err.
- LEN: LEN=0 or LEN>MAX_LEN pulses pkt_err and returns to HUNT1. Otherwise LEN is stored, the running sum is loaded with LEN, the write index is cleared, and the state moves to PAYLOAD.
- PAYLOAD: each byte is written at the write index, the index increments, and the byte is added to the sum. After the LEN-th byte, go to CHK.
- CHK: on a match, pulse pkt_ok and go to DRAIN. On a mismatch, pulse pkt_err and go to HUNT1.
- DRAIN: read index runs 0..LEN-1. pl_last is high when read index = LEN-1. The handshake on the last byte returns the state to HUNT1.
- During DRAIN every rx_valid byte is discarded and sets overrun. The parser does not sync on bytes received during DRAIN.
- Parity: rx_valid with rx_perr in LEN, PAYLOAD or CHK pulses pkt_err and returns to HUNT1. In HUNT2 it returns to HUNT1 without pkt_err.
- Timeout: a gap counter is cleared on every rx_valid and counts while in LEN, PAYLOAD or CHK. On reaching TIMEOUT it pulses pkt_err and returns to HUNT1. The counter is idle in HUNT1, HUNT2 and DRAIN.
- A rejected frame never produces pl_valid.

## Timing
- Reset (async assert, sync release) puts the block in HUNT1 with all outputs 0: pl_data=0x00, pl_valid=0, pl_last=0, pkt_ok=0, pkt_err=0, overrun=0. Indices, sum and timer are also cleared.
- Reset mid-frame or mid-DRAIN abandons the frame immediately, with no pulses.
- All outputs are registered.
- pkt_ok and pkt_err assert in the cycle after the rx_valid cycle that decides them.
- pl_valid rises in the same cycle as pkt_ok, carrying byte 0.
- With pl_ready held high, one byte transfers per cycle, so a LEN-byte frame drains in LEN cycles.
- pl_data and pl_last stay stable while pl_valid=1 and pl_ready=0.
- pl_valid drops the cycle after the last handshake, in HUNT1. The next frame's 0xAA can be accepted in that same cycle.
- Timeout fires exactly TIMEOUT cycles after the last rx_valid. pkt_err is registered one cycle later.
- A timeout coinciding with rx_valid: the byte wins and the timer restarts.
- pkt_ok and pkt_err are never high together.

## Test plan
- Good frame: AA 55 03 10 20 30 63, pl_ready=1. Expect a pkt_ok pulse, then pl 10, 20, 30 on consecutive cycles, pl_last only on 30, and no pkt_err.
- Bad checksum: AA 55 03 10 20 30 64. Expect one pkt_err and pl_valid never high. A following good frame is still accepted.
- Length and parity errors:
  - AA 55 00 gives pkt_err.
  - With MAX_LEN=32, AA 55 21 gives pkt_err.
  - rx_perr=1 on the second payload byte of a valid frame gives pkt_err and a return to HUNT1.
- Sync recovery: 12 AA AA 55 01 7F 80 gives pkt_ok and a single byte 7F with pl_last. AA 13 55 ... gives no frame.
- Backpressure and overrun: good 4-byte frame with pl_ready toggled 1,0,0,1,... Data must be held stable. A byte injected during DRAIN sets overrun, which clears on the next pkt_ok.
- Timeout and reset: with TIMEOUT=100, stop after AA 55 02 10.
  - Expect pkt_err 101 cycles after the last strobe.
  - Separately, assert rst_n=0 mid-DRAIN: all outputs go to 0 immediately, and a fresh frame then passes.
